// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types and arbiter constants for the cbus_arbiter slice.
package cbus_arbiter_pkg;

  localparam int CBUS_NREQ = 2;

  typedef enum logic [1:0] {
    MLEN1 = 2'd0,
    MLEN2 = 2'd1,
    MLEN4 = 2'd2,
    MLEN8 = 2'd3
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    cbus_len_t   len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  // A single requester still needs a one-bit grant index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundles the upstream request/response arrays and the merged MMU-side channel.
interface cbus_arbiter_if
  import cbus_arbiter_pkg::*;
#(
  parameter int NREQ = CBUS_NREQ
) ();
  localparam int IDX_W = idx_width(NREQ);

  cbus_req_t  [NREQ-1:0] ireqs;
  cbus_resp_t [NREQ-1:0] iresps;
  cbus_req_t             oreq;
  cbus_resp_t            oresp;
  logic                  request_valid;
  logic [IDX_W-1:0]      grant_idx;

  // slave is the arbiter's view; master is the requesters-plus-MMU environment.
  modport slave  (input  ireqs, oresp, output iresps, oreq, request_valid, grant_idx);
  modport master (output ireqs, oresp, input  iresps, oreq, request_valid, grant_idx);
endinterface

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational winner search: round-robin from ptr, or lowest index wins when
// CBUS_ARB_FIXED_PRIO_EN is defined (the pointer port then disappears).
module cbus_arbiter_rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  valid,
`ifndef CBUS_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  // NOTE: every output is defaulted at the top of the always_comb so no path can infer a latch.
`ifdef CBUS_ARB_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    winner = '0;
    // Scanning downwards lets the lowest asserted index overwrite any higher one.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        found  = 1'b1;
        winner = IDX_W'(i);
      end
    end
  end
`else
  logic [NREQ-1:0] rot;

  always_comb begin
    int sum;
    found  = 1'b0;
    winner = '0;
    sum    = 0;
    // rot[k] is requester (ptr + k) mod NREQ; the smallest offset wins.
    rot    = NREQ'({valid, valid} >> ptr);
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        found  = 1'b1;
        winner = IDX_W'(sum);
      end
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Merges NREQ cbus requesters onto the single MMU request stream, holding the grant for a
// whole transaction. Define CBUS_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NREQ  = CBUS_NREQ,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic          clk,
  input  logic          reset,
  cbus_arbiter_if.slave bus
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [NREQ-1:0]  valid_vec;
  logic             found;
  logic [IDX_W-1:0] winner;

  always_comb begin
    for (int i = 0; i < NREQ; i++) valid_vec[i] = bus.ireqs[i].valid;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef CBUS_ARB_FIXED_PRIO_EN
  cbus_arbiter_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .valid  (valid_vec),
    .found  (found),
    .winner (winner)
  );
`else
  logic [IDX_W-1:0] ptr_q;

  cbus_arbiter_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .valid  (valid_vec),
    .ptr    (ptr_q),
    .found  (found),
    .winner (winner)
  );

  // The search start only moves past the last winner once its transaction is over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (state_q == ARB_GAP) begin
      ptr_q <= (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
    end
  end
`endif

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    bus.oreq          = '0;
    bus.iresps        = '0;
    bus.request_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        bus.oreq              = bus.ireqs[grant_q];
        bus.iresps[grant_q]   = bus.oresp;
        bus.request_valid     = 1'b1;
        // A final beat and a requester abort both close the grant the same way.
        if ((bus.oresp.ready && bus.oresp.last) || !bus.ireqs[grant_q].valid) begin
          state_d = ARB_GAP;
        end
      end
      ARB_GAP: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus randomized traffic against
// a transaction-level arbitration model.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int NREQ     = CBUS_NREQ;
  localparam int IDX_W    = idx_width(NREQ);
  localparam int MAX_BUSY = 64;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         model_ptr = 0;
  cbus_req_t  req [NREQ];
  cbus_resp_t resp;

  cbus_arbiter_if #(.NREQ(NREQ)) bus ();

  cbus_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) bus.ireqs[i] = req[i];
    bus.oresp = resp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] valids();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = req[i].valid;
    return v;
  endfunction

  // Reference arbitration rule: first asserted requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
`ifdef CBUS_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic int beats_of(input cbus_len_t len);
    case (len)
      MLEN1:   return 1;
      MLEN2:   return 2;
      MLEN4:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic cbus_req_t rand_req();
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.addr     = $urandom & 32'hFFFF_FFFC;
    r.len      = cbus_len_t'($urandom_range(0, 3));
    r.strobe   = 4'($urandom_range(0, 15));
    r.data     = $urandom;
    return r;
  endfunction

  // Called inside the IDLE decision cycle; returns the model's winner and steps into BUSY.
  task automatic arbitrate(output int exp, input string tag);
    @(negedge clk);
    exp = model_pick(valids(), model_ptr);
    checks++;
    if (bus.request_valid !== 1'b0 || bus.oreq !== '0 || bus.iresps !== '0) begin
      errors++;
      $display("FAIL %s decision cycle: rv=%b oreq=%h iresps=%h, want all zero",
               tag, bus.request_valid, bus.oreq, bus.iresps);
    end
    tick();
  endtask

  // Acts as the MMU for one granted transaction, then checks the GAP cycle.
  task automatic serve(input int exp, input int abort_after, input bit last_with_abort,
                       input bit keep, input string tag);
    int beats_total;
    int beats_sent;
    int beats_seen;
    int busy;
    bit done;
    cbus_resp_t [NREQ-1:0] exp_resps;
    beats_total = beats_of(req[exp].len);
    beats_sent  = 0;
    beats_seen  = 0;
    busy        = 0;
    done        = 1'b0;
    while (!done) begin
      @(negedge clk);
      exp_resps      = '0;
      exp_resps[exp] = resp;
      checks++;
      if (bus.request_valid !== 1'b1 || bus.grant_idx !== IDX_W'(exp) ||
          bus.oreq !== req[exp] || bus.iresps !== exp_resps) begin
        errors++;
        $display("FAIL %s busy[%0d]: rv=%b grant=%0d oreq=%h iresps=%h, want rv=1 grant=%0d oreq=%h iresps=%h",
                 tag, busy, bus.request_valid, bus.grant_idx, bus.oreq, bus.iresps,
                 exp, req[exp], exp_resps);
      end
      if (bus.iresps[exp].ready === 1'b1) beats_seen++;
      if ((resp.ready && resp.last) || !req[exp].valid) begin
        done = 1'b1;
      end else if (busy >= MAX_BUSY) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: %0d busy cycles without completion, want < %0d",
                 tag, busy, MAX_BUSY);
        done = 1'b1;
      end else begin
        tick();
        busy++;
        resp = '0;
        if (abort_after > 0) begin
          if (busy == abort_after) begin
            req[exp].valid = 1'b0;
            if (last_with_abort) begin
              resp.ready = 1'b1;
              resp.last  = 1'b1;
              resp.data  = $urandom;
            end
          end
        end else if ($urandom_range(0, 2) != 0) begin
          beats_sent++;
          resp.ready = 1'b1;
          resp.last  = (beats_sent == beats_total);
          resp.data  = $urandom;
        end
        drive();
      end
    end
    if (abort_after == 0) begin
      checks++;
      if (beats_seen != beats_total) begin
        errors++;
        $display("FAIL %s beat count: forwarded=%0d, want %0d", tag, beats_seen, beats_total);
      end
    end
    tick();
    resp = '0;
    if (!keep) req[exp].valid = 1'b0;
    drive();
    @(negedge clk);
    checks++;
    if (bus.request_valid !== 1'b0 || bus.oreq !== '0 || bus.iresps !== '0 ||
        bus.grant_idx !== IDX_W'(exp)) begin
      errors++;
      $display("FAIL %s gap cycle: rv=%b oreq=%h iresps=%h grant=%0d, want rv=0 zeros grant=%0d",
               tag, bus.request_valid, bus.oreq, bus.iresps, bus.grant_idx, exp);
    end
    model_ptr = (exp + 1) % NREQ;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    resp  = '0;
    reset = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.request_valid !== 1'b0 || bus.oreq !== '0 || bus.iresps !== '0 ||
        bus.grant_idx !== '0 || dut.state_q !== ARB_IDLE) begin
      errors++;
      $display("FAIL reset: rv=%b oreq=%h iresps=%h grant=%0d state=%0d, want zeros and IDLE",
               bus.request_valid, bus.oreq, bus.iresps, bus.grant_idx, dut.state_q);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.request_valid !== 1'b0 || bus.grant_idx !== '0) begin
      errors++;
      $display("FAIL reset release: rv=%b grant=%0d, want rv=0 grant=0",
               bus.request_valid, bus.grant_idx);
    end
    model_ptr = 0;
  endtask

  task automatic test_single();
    int e;
    cbus_resp_t [NREQ-1:0] exp_resps;
    tick();
    req[1] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h8000_1000, len: MLEN1,
               strobe: 4'hF, data: 32'h0};
    drive();
    arbitrate(e, "single");
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.request_valid !== 1'b1 || bus.grant_idx !== IDX_W'(e) || bus.oreq !== req[e]) begin
        errors++;
        $display("FAIL single cycle %0d: rv=%b grant=%0d oreq=%h, want rv=1 grant=%0d oreq=%h",
                 c, bus.request_valid, bus.grant_idx, bus.oreq, e, req[e]);
      end
      tick();
    end
    resp = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};
    drive();
    @(negedge clk);
    exp_resps    = '0;
    exp_resps[1] = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};
    checks++;
    if (bus.iresps !== exp_resps) begin
      errors++;
      $display("FAIL single response: iresps=%h, want %h", bus.iresps, exp_resps);
    end
    tick();
    resp          = '0;
    req[1].valid  = 1'b0;
    drive();
    @(negedge clk);
    checks++;
    if (bus.request_valid !== 1'b0 || bus.oreq !== '0 || bus.iresps !== '0) begin
      errors++;
      $display("FAIL single gap: rv=%b oreq=%h iresps=%h, want zeros",
               bus.request_valid, bus.oreq, bus.iresps);
    end
    model_ptr = (e + 1) % NREQ;
  endtask

  task automatic test_contention();
    int e;
    for (int pair = 0; pair < 2; pair++) begin
      tick();
      req[0] = rand_req();
      req[1] = rand_req();
      drive();
      for (int n = 0; n < 2; n++) begin
        if (n > 0) begin
          tick();
          drive();
        end
        arbitrate(e, "contention");
        serve(e, 0, 1'b0, 1'b0, "contention");
      end
    end
  endtask

  task automatic test_burst();
    int e;
    tick();
    req[0]     = rand_req();
    req[0].len = MLEN4;
    req[0].is_write = 1'b0;
    drive();
    arbitrate(e, "burst");
    serve(e, 0, 1'b0, 1'b0, "burst");
  endtask

  task automatic test_abort();
    int e;
    tick();
    req[1]     = rand_req();
    req[1].len = MLEN4;
    drive();
    arbitrate(e, "abort");
    req[0] = rand_req();
    drive();
    serve(e, 2, 1'b0, 1'b0, "abort");
    tick();
    drive();
    arbitrate(e, "after_abort");
    serve(e, 0, 1'b0, 1'b0, "after_abort");
  endtask

  // Both requesters stay valid across grants; the model decides who must win each round.
  task automatic test_priority();
    int e;
    tick();
    req[0] = rand_req();
    req[1] = rand_req();
    drive();
    for (int n = 0; n < 4; n++) begin
      if (n > 0) begin
        tick();
        drive();
      end
      arbitrate(e, "priority");
      serve(e, 0, 1'b0, 1'b1, "priority");
    end
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    drive();
  endtask

  task automatic test_random();
    int e;
    int abort_after;
    for (int round = 0; round < 40; round++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i].valid && $urandom_range(0, 1) == 1) req[i] = rand_req();
      end
      drive();
      tick();
      if (valids() == '0) req[$urandom_range(0, NREQ - 1)] = rand_req();
      drive();
      arbitrate(e, "random");
      abort_after = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      serve(e, abort_after, 1'($urandom_range(0, 1)), 1'b0, "random");
    end
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    drive();
  endtask

  task automatic test_reset_mid_burst();
    int e;
    tick();
    req[1]          = rand_req();
    req[1].len      = MLEN4;
    req[1].is_write = 1'b0;
    drive();
    arbitrate(e, "reset_mid_burst");
    tick();
    resp = '{ready: 1'b1, last: 1'b0, data: $urandom};
    drive();
    tick();
    resp = '{ready: 1'b1, last: 1'b0, data: $urandom};
    drive();
    @(negedge clk);
    checks++;
    if (bus.request_valid !== 1'b1 || bus.grant_idx !== IDX_W'(e)) begin
      errors++;
      $display("FAIL reset_mid_burst pre: rv=%b grant=%0d, want rv=1 grant=%0d",
               bus.request_valid, bus.grant_idx, e);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.request_valid !== 1'b0 || bus.oreq !== '0 || bus.iresps !== '0 ||
        bus.grant_idx !== '0 || dut.state_q !== ARB_IDLE) begin
      errors++;
      $display("FAIL reset_mid_burst async: rv=%b oreq=%h iresps=%h grant=%0d state=%0d, want zeros and IDLE",
               bus.request_valid, bus.oreq, bus.iresps, bus.grant_idx, dut.state_q);
    end
    resp = '0;
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    drive();
    tick();
    reset     = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    checks++;
    if (bus.request_valid !== 1'b0 || bus.grant_idx !== '0) begin
      errors++;
      $display("FAIL reset_mid_burst release: rv=%b grant=%0d, want rv=0 grant=0",
               bus.request_valid, bus.grant_idx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_abort();
    test_priority();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
